// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use hazard detection and branch flush.
// A load in EX whose destination feeds the instruction in ID stalls IF/ID and
// the PC for exactly one cycle and requests a bubble into ID/EX. A taken branch
// flushes the register to a NOP.
// Optional: define IF_ID_PERF_CNT_EN to build saturating stall/flush counters;
// otherwise stall_cnt and flush_cnt are tied to zero.
module if_id_hazard #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      pc_plus4_in,
  input  logic             instr_valid_in,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  output logic [31:0]      instr_id,
  output logic [31:0]      pc_plus4_id,
  output logic             valid_id,
  output logic             pc_write,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 6;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              stall_now;
  logic              hazard;
  logic              uses_rt;
  logic [OP_W-1:0]   opcode;
  logic [REG_W-1:0]  rs, rt;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];

  // Operand-usage decode and load-use hazard detection on the ID instruction
  always_comb begin
    uses_rt = (opcode == 6'h00) || (opcode == 6'h2B) ||
              (opcode == 6'h04) || (opcode == 6'h05);
    hazard  = valid_q && ex_mem_read && (ex_rt != '0) &&
              ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: a stall lasts one cycle, a flush always returns to RUN
  always_comb begin
    state_d = ST_RUN;
    if ((state_q == ST_RUN) && stall_now && !branch_taken) state_d = ST_STALL;
  end

  // FSM outputs: hazard only acts while running
  always_comb begin
    stall_now = 1'b0;
    if (state_q == ST_RUN) stall_now = hazard;
    pc_write = ~stall_now;
    bubble   = stall_now;
  end

  // Pipeline register next value: flush beats stall beats capture
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (branch_taken) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (!stall_now) begin
      instr_d = instr_in;
      pc_d    = pc_plus4_in;
      valid_d = instr_valid_in;
    end
  end

  // Pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_id    = instr_q;
  assign pc_plus4_id = pc_q;
  assign valid_id    = valid_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: stalls that actually hold the pipe, and flushes
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_now && !branch_taken && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (branch_taken && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_hazard.sv
// Directed bench for if_id_hazard: capture, load-use stall, rt/$0 rules,
// flush-over-stall priority and reset during a stall.
module tb_if_id_hazard;

  localparam int unsigned CNT_W = 16;
`ifdef IF_ID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      instr_in, pc_plus4_in;
  logic             instr_valid_in, ex_mem_read, branch_taken;
  logic [4:0]       ex_rt;
  logic [31:0]      instr_id, pc_plus4_id;
  logic             valid_id, pc_write, bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  if_id_hazard #(.NOP_WORD(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_in(instr_in), .pc_plus4_in(pc_plus4_in),
    .instr_valid_in(instr_valid_in), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .branch_taken(branch_taken),
    .instr_id(instr_id), .pc_plus4_id(pc_plus4_id), .valid_id(valid_id),
    .pc_write(pc_write), .bubble(bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    instr_in    = ins;
    pc_plus4_in = pc;
  endtask

  initial begin
    rst_n = 1'b0; instr_in = '0; pc_plus4_in = '0; instr_valid_in = 1'b0;
    ex_mem_read = 1'b0; ex_rt = '0; branch_taken = 1'b0;
    #12;
    check("rst_instr", instr_id, 32'h0);
    check("rst_pc", pc_plus4_id, 32'h0);
    check("rst_valid", 32'(valid_id), 32'h0);
    check("rst_pcw", 32'(pc_write), 32'h1);
    check("rst_bubble", 32'(bubble), 32'h0);
    check("rst_scnt", 32'(stall_cnt), 32'h0);
    check("rst_fcnt", 32'(flush_cnt), 32'h0);

    @(negedge clk); rst_n = 1'b1;
    drive(32'h0109_5020, 32'd4); instr_valid_in = 1'b1;
    tick();
    check("cap_instr", instr_id, 32'h0109_5020);
    check("cap_pc", pc_plus4_id, 32'd4);
    check("cap_valid", 32'(valid_id), 32'h1);
    check("cap_pcw", 32'(pc_write), 32'h1);
    check("cap_bubble", 32'(bubble), 32'h0);

    // load-use on rs ($8)
    ex_mem_read = 1'b1; ex_rt = 5'd8;
    drive(32'hAC89_0000, 32'd8);
    #1;
    check("rs_bubble", 32'(bubble), 32'h1);
    check("rs_pcw", 32'(pc_write), 32'h0);
    tick();
    check("stall_hold_instr", instr_id, 32'h0109_5020);
    check("stall_hold_pc", pc_plus4_id, 32'd4);
    check("stall_state_bubble", 32'(bubble), 32'h0);
    check("stall_state_pcw", 32'(pc_write), 32'h1);
    check("scnt_1", 32'(stall_cnt), PERF ? 32'd1 : 32'd0);
    tick();
    check("adv_instr", instr_id, 32'hAC89_0000);
    check("adv_pc", pc_plus4_id, 32'd8);
    check("sw_rt8_bubble", 32'(bubble), 32'h0);

    // sw uses rt ($9)
    ex_rt = 5'd9; drive(32'h8C89_0000, 32'd12);
    #1;
    check("sw_rt9_bubble", 32'(bubble), 32'h1);
    tick();
    check("sw_hold", instr_id, 32'hAC89_0000);
    tick();
    check("lw_cap", instr_id, 32'h8C89_0000);
    check("lw_rt9_bubble", 32'(bubble), 32'h0);
    check("lw_rt9_pcw", 32'(pc_write), 32'h1);

    // $0 never stalls: add $8,$0,$0
    ex_mem_read = 1'b0; drive(32'h0000_4020, 32'd16);
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd0;
    #1;
    check("zero_instr", instr_id, 32'h0000_4020);
    check("zero_bubble", 32'(bubble), 32'h0);

    // flush beats hazard
    ex_mem_read = 1'b0; drive(32'h0109_5020, 32'd20);
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd9; branch_taken = 1'b1;
    drive(32'h0085_1020, 32'd24);
    #1;
    check("both_bubble", 32'(bubble), 32'h1);
    tick();
    branch_taken = 1'b0;
    check("flush_instr", instr_id, 32'h0);
    check("flush_valid", 32'(valid_id), 32'h0);
    check("flush_pc", pc_plus4_id, 32'd20);
    check("flush_bubble", 32'(bubble), 32'h0);
    check("flush_fcnt", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
    check("flush_scnt", 32'(stall_cnt), PERF ? 32'd2 : 32'd0);
    tick();
    check("post_flush_run", instr_id, 32'h0085_1020);

    // reset during STALL
    ex_mem_read = 1'b0; drive(32'h0109_5020, 32'd28);
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd8;
    tick();
    check("pre_rst_stall_hold", instr_id, 32'h0109_5020);
    check("pre_rst_stall_bubble", 32'(bubble), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_instr", instr_id, 32'h0);
    check("mid_rst_pc", pc_plus4_id, 32'h0);
    check("mid_rst_valid", 32'(valid_id), 32'h0);
    check("mid_rst_pcw", 32'(pc_write), 32'h1);
    check("mid_rst_bubble", 32'(bubble), 32'h0);
    check("mid_rst_scnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; ex_mem_read = 1'b0; drive(32'h0085_1020, 32'd32);
    tick();
    check("rel_instr", instr_id, 32'h0085_1020);
    check("rel_pc", pc_plus4_id, 32'd32);
    check("rel_valid", 32'(valid_id), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
